// File: rtl/cmp_result_filter.sv
// -----------------------------------------------------------------------------
// cmp_result_filter
//
// Debounce and event-tracking stage that sits directly after the 4-bit
// magnitude comparator. Valid one-hot comparator results are classified as
// ABOVE, BELOW or EQ. A new relation is committed only after DEBOUNCE
// consecutive identical valid samples. Committed entries into each relation
// are counted in saturating counters.
//
// Build option:
//   CMP_RESULT_CHECK_EN  defined   : a malformed valid sample sets the sticky
//                                    err flag and restarts the streak.
//                        undefined : a malformed valid sample is ignored like
//                                    an in_valid-low cycle; err is tied to 0.
//
// Parameters:
//   DEBOUNCE   consecutive identical valid samples needed to commit (1..15)
//   CNT_W      width of each saturating event counter
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   sample strobe for the comparator outputs
//   a_gt_b     in   comparator A>B
//   a_lt_b     in   comparator A<B
//   a_eq_b     in   comparator A==B
//   clr        in   synchronous clear of the counters and err
//   state      out  committed relation: 00 IDLE, 01 EQ, 10 ABOVE, 11 BELOW
//   state_chg  out  one-cycle pulse after a commit edge
//   gt_cnt     out  entries into ABOVE
//   lt_cnt     out  entries into BELOW
//   eq_cnt     out  entries into EQ
//   err        out  sticky malformed-sample flag
// -----------------------------------------------------------------------------
module cmp_result_filter #(
   parameter int unsigned DEBOUNCE = 3,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             a_gt_b,
   input  logic             a_lt_b,
   input  logic             a_eq_b,
   input  logic             clr,
   output logic [1:0]       state,
   output logic             state_chg,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic             err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_EQ    = 2'b01,
      ST_ABOVE = 2'b10,
      ST_BELOW = 2'b11
   } rel_e;

   localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // The candidate reuses the relation encoding; ST_IDLE stands for "no
   // candidate", which can never match a classified sample.
   rel_e             state_q, state_d;
   rel_e             cand_q, cand_d;
   logic [3:0]       streak_q, streak_d;
   logic             chg_q, chg_d;
   logic [CNT_W-1:0] gt_q, gt_d;
   logic [CNT_W-1:0] lt_q, lt_d;
   logic [CNT_W-1:0] eq_q, eq_d;

   rel_e             cls;
   logic             code_ok;
   logic             smp_legal;
   logic             commit;

   // Sample classification: only the three one-hot codes are legal.
   always_comb begin
      cls     = ST_IDLE;
      code_ok = 1'b0;
      case ({a_gt_b, a_lt_b, a_eq_b})
         3'b100:  begin cls = ST_ABOVE; code_ok = 1'b1; end
         3'b010:  begin cls = ST_BELOW; code_ok = 1'b1; end
         3'b001:  begin cls = ST_EQ;    code_ok = 1'b1; end
         default: begin cls = ST_IDLE;  code_ok = 1'b0; end
      endcase
   end

   assign smp_legal = in_valid & code_ok;

`ifdef CMP_RESULT_CHECK_EN
   logic err_q, err_d;
   logic smp_illegal;
   assign smp_illegal = in_valid & ~code_ok;
`endif

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      streak_d = streak_q;
      chg_d    = 1'b0;
      commit   = 1'b0;
      gt_d     = gt_q;
      lt_d     = lt_q;
      eq_d     = eq_q;
`ifdef CMP_RESULT_CHECK_EN
      err_d    = err_q;
`endif

      if (smp_legal) begin
         if (cls == cand_q) begin
            streak_d = (streak_q >= DEB) ? DEB : streak_q + 4'd1;
         end else begin
            cand_d   = cls;
            streak_d = 4'd1;
         end
         // Commit is judged on the updated streak so the DEBOUNCE-th sample
         // commits on its own edge; matching the current state never recounts.
         if ((streak_d == DEB) && (cand_d != state_q)) begin
            commit  = 1'b1;
            state_d = cand_d;
            chg_d   = 1'b1;
         end
      end
`ifdef CMP_RESULT_CHECK_EN
      else if (smp_illegal) begin
         cand_d   = ST_IDLE;
         streak_d = '0;
         err_d    = 1'b1;
      end
`endif

      if (commit) begin
         case (cand_d)
            ST_ABOVE: if (gt_q != CNT_MAX) gt_d = gt_q + CNT_ONE;
            ST_BELOW: if (lt_q != CNT_MAX) lt_d = lt_q + CNT_ONE;
            ST_EQ:    if (eq_q != CNT_MAX) eq_d = eq_q + CNT_ONE;
            default:  ;
         endcase
      end

      // Clear overrides any coincident increment but leaves the relation
      // tracking (state, candidate, streak, pulse) alone.
      if (clr) begin
         gt_d = '0;
         lt_d = '0;
         eq_d = '0;
`ifdef CMP_RESULT_CHECK_EN
         err_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cand_q   <= ST_IDLE;
         streak_q <= '0;
         chg_q    <= 1'b0;
         gt_q     <= '0;
         lt_q     <= '0;
         eq_q     <= '0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         streak_q <= streak_d;
         chg_q    <= chg_d;
         gt_q     <= gt_d;
         lt_q     <= lt_d;
         eq_q     <= eq_d;
      end
   end

`ifdef CMP_RESULT_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign state     = state_q;
   assign state_chg = chg_q;
   assign gt_cnt    = gt_q;
   assign lt_cnt    = lt_q;
   assign eq_cnt    = eq_q;

endmodule

// File: tb/tb_cmp_result_filter.sv
// -----------------------------------------------------------------------------
// tb_cmp_result_filter
//
// Self-checking bench for cmp_result_filter with DEBOUNCE=3, CNT_W=8.
// Expected observations are pushed to a queue as each stimulus cycle is
// driven and popped for comparison once the DUT has taken the edge.
// Expectations for the malformed-sample scenario follow CMP_RESULT_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_cmp_result_filter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       a_gt_b = 1'b0;
   logic       a_lt_b = 1'b0;
   logic       a_eq_b = 1'b0;
   logic       clr = 1'b0;
   logic [1:0] state;
   logic       state_chg;
   logic [7:0] gt_cnt;
   logic [7:0] lt_cnt;
   logic [7:0] eq_cnt;
   logic       err;

   cmp_result_filter #(
      .DEBOUNCE (3),
      .CNT_W    (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a_gt_b    (a_gt_b),
      .a_lt_b    (a_lt_b),
      .a_eq_b    (a_eq_b),
      .clr       (clr),
      .state     (state),
      .state_chg (state_chg),
      .gt_cnt    (gt_cnt),
      .lt_cnt    (lt_cnt),
      .eq_cnt    (eq_cnt),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] st;
      logic       chg;
      logic [7:0] gt;
      logic [7:0] lt;
      logic [7:0] eq;
      logic       err;
   } obs_t;

   obs_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   // Expected counter/err values, advanced by the scenario tables.
   logic [7:0] m_gt, m_lt, m_eq;
   logic       m_err;

   function automatic obs_t dut_obs();
      obs_t o;
      o.st  = state;
      o.chg = state_chg;
      o.gt  = gt_cnt;
      o.lt  = lt_cnt;
      o.eq  = eq_cnt;
      o.err = err;
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("st=%b chg=%b gt=%0d lt=%0d eq=%0d err=%b",
                       o.st, o.chg, o.gt, o.lt, o.eq, o.err);
   endfunction

   // Push the expectation for the next edge: a clear zeroes the counters,
   // otherwise an expected pulse means one more entry into that relation.
   task automatic expect_step(input logic [1:0] st, input logic chg, input logic cl);
      obs_t e;
      if (cl) begin
         m_gt = 8'd0; m_lt = 8'd0; m_eq = 8'd0; m_err = 1'b0;
      end else if (chg) begin
         case (st)
            2'b10:   if (m_gt != 8'hFF) m_gt = m_gt + 8'd1;
            2'b11:   if (m_lt != 8'hFF) m_lt = m_lt + 8'd1;
            2'b01:   if (m_eq != 8'hFF) m_eq = m_eq + 8'd1;
            default: ;
         endcase
      end
      e.st = st; e.chg = chg; e.gt = m_gt; e.lt = m_lt; e.eq = m_eq; e.err = m_err;
      sbq.push_back(e);
   endtask

   task automatic push_zero();
      obs_t e;
      e = '0;
      sbq.push_back(e);
   endtask

   task automatic drive(input logic v, input logic [2:0] code, input logic cl);
      in_valid = v;
      {a_gt_b, a_lt_b, a_eq_b} = code;
      clr = cl;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      {a_gt_b, a_lt_b, a_eq_b} = 3'b000;
      clr = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      @(posedge clk);
      #3;
      rst = 1'b0;
      m_gt = 8'd0; m_lt = 8'd0; m_eq = 8'd0; m_err = 1'b0;
   endtask

   task automatic test_reset();
      obs_t e, g;
      drive(1'b1, 3'b100, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      push_zero();
      e = sbq.pop_front(); g = dut_obs(); total++;
      if (g !== e) begin
         bad++; $display("FAIL reset_async: got %s want %s", fmt(g), fmt(e));
      end
      @(posedge clk);
      #1;
      push_zero();
      e = sbq.pop_front(); g = dut_obs(); total++;
      if (g !== e) begin
         bad++; $display("FAIL reset_held: got %s want %s", fmt(g), fmt(e));
      end
      #2;
      rst = 1'b0;
      m_gt = 8'd0; m_lt = 8'd0; m_eq = 8'd0; m_err = 1'b0;
   endtask

   task automatic test_basic_commit();
      // {valid, gt, lt, eq}; expected {state, chg}
      logic [3:0] stim [5] = '{4'b1100, 4'b1100, 4'b1100, 4'b0000, 4'b1100};
      logic [2:0] expv [5] = '{3'b000, 3'b000, 3'b101, 3'b100, 3'b100};
      obs_t e, g;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         expect_step(expv[i][2:1], expv[i][0], 1'b0);
         drive(stim[i][3], stim[i][2:0], 1'b0);
         e = sbq.pop_front(); g = dut_obs(); total++;
         if (g !== e) begin
            bad++; $display("FAIL basic[%0d]: got %s want %s", i, fmt(g), fmt(e));
         end
      end
   endtask

   task automatic test_streak_gaps();
      logic [2:0] codes [5] = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b001};
      logic [2:0] expv  [5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b011};
      obs_t e, g;
      for (int gap = 0; gap <= 2; gap += 2) begin
         do_reset();
         for (int i = 0; i < 5; i++) begin
            expect_step(expv[i][2:1], expv[i][0], 1'b0);
            drive(1'b1, codes[i], 1'b0);
            e = sbq.pop_front(); g = dut_obs(); total++;
            if (g !== e) begin
               bad++; $display("FAIL streak_gap%0d[%0d]: got %s want %s", gap, i, fmt(g), fmt(e));
            end
            if (i < 4) begin
               for (int k = 0; k < gap; k++) begin
                  expect_step(expv[i][2:1], 1'b0, 1'b0);
                  drive(1'b0, codes[i + 1], 1'b0);
                  e = sbq.pop_front(); g = dut_obs(); total++;
                  if (g !== e) begin
                     bad++; $display("FAIL streak_hold%0d[%0d]: got %s want %s", gap, i, fmt(g), fmt(e));
                  end
               end
            end
         end
      end
   endtask

   task automatic test_malformed();
      // expected {err, state, chg}
`ifdef CMP_RESULT_CHECK_EN
      localparam int N = 6;
      logic [2:0] codes [N] = '{3'b100, 3'b100, 3'b110, 3'b100, 3'b100, 3'b100};
      logic [3:0] expv  [N] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1101};
`else
      localparam int N = 4;
      logic [2:0] codes [N] = '{3'b100, 3'b100, 3'b110, 3'b100};
      logic [3:0] expv  [N] = '{4'b0000, 4'b0000, 4'b0000, 4'b0101};
`endif
      obs_t e, g;
      do_reset();
      for (int i = 0; i < N; i++) begin
         m_err = expv[i][3];
         expect_step(expv[i][2:1], expv[i][0], 1'b0);
         drive(1'b1, codes[i], 1'b0);
         e = sbq.pop_front(); g = dut_obs(); total++;
         if (g !== e) begin
            bad++; $display("FAIL malformed[%0d]: got %s want %s", i, fmt(g), fmt(e));
         end
      end
   endtask

   task automatic test_saturation_clear();
      logic [1:0] ps;
      logic [1:0] st;
      logic [2:0] code;
      logic       chg;
      obs_t       e, g;
      do_reset();
      ps = 2'b00;
      for (int p = 0; p < 260; p++) begin
         for (int b = 0; b < 2; b++) begin
            code = (b == 0) ? 3'b100 : 3'b010;
            for (int k = 0; k < 3; k++) begin
               chg = (k == 2);
               st  = chg ? ((b == 0) ? 2'b10 : 2'b11) : ps;
               expect_step(st, chg, 1'b0);
               drive(1'b1, code, 1'b0);
               e = sbq.pop_front(); g = dut_obs(); total++;
               if (g !== e) begin
                  bad++; $display("FAIL sat[%0d.%0d.%0d]: got %s want %s", p, b, k, fmt(g), fmt(e));
               end
               if (chg) ps = st;
            end
         end
      end
      total++;
      if (gt_cnt !== 8'd255 || lt_cnt !== 8'd255) begin
         bad++; $display("FAIL sat_hold: got gt=%0d lt=%0d want gt=255 lt=255", gt_cnt, lt_cnt);
      end
      // gt block with clear on its commit edge, then lt block likewise (the
      // lt counter would otherwise read 1), then a plain gt block.
      for (int b = 0; b < 3; b++) begin
         code = (b == 1) ? 3'b010 : 3'b100;
         for (int k = 0; k < 3; k++) begin
            chg = (k == 2);
            st  = chg ? ((b == 1) ? 2'b11 : 2'b10) : ps;
            expect_step(st, chg, chg && (b < 2));
            drive(1'b1, code, chg && (b < 2));
            e = sbq.pop_front(); g = dut_obs(); total++;
            if (g !== e) begin
               bad++; $display("FAIL clr[%0d.%0d]: got %s want %s", b, k, fmt(g), fmt(e));
            end
            if (chg) ps = st;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] codes [5] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100};
      logic [2:0] expv  [5] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b110};
      obs_t e, g;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         expect_step(expv[i][2:1], expv[i][0], 1'b0);
         drive(1'b1, codes[i], 1'b0);
         e = sbq.pop_front(); g = dut_obs(); total++;
         if (g !== e) begin
            bad++; $display("FAIL rstmid_pre[%0d]: got %s want %s", i, fmt(g), fmt(e));
         end
      end
      #2;
      rst = 1'b1;
      #1;
      push_zero();
      e = sbq.pop_front(); g = dut_obs(); total++;
      if (g !== e) begin
         bad++; $display("FAIL rstmid_async: got %s want %s", fmt(g), fmt(e));
      end
      @(posedge clk);
      #3;
      rst = 1'b0;
      m_gt = 8'd0; m_lt = 8'd0; m_eq = 8'd0; m_err = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_step((i == 2) ? 2'b10 : 2'b00, (i == 2), 1'b0);
         drive(1'b1, 3'b100, 1'b0);
         e = sbq.pop_front(); g = dut_obs(); total++;
         if (g !== e) begin
            bad++; $display("FAIL rstmid_post[%0d]: got %s want %s", i, fmt(g), fmt(e));
         end
      end
   endtask

   initial begin
      m_gt = 8'd0; m_lt = 8'd0; m_eq = 8'd0; m_err = 1'b0;
      test_reset();
      test_basic_commit();
      test_streak_gaps();
      test_malformed();
      test_saturation_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cmp_result_filter.md
# cmp_result_filter

Debounce and event-tracking stage directly downstream of the 4-bit magnitude comparator. Each cycle with `in_valid` high, it samples the comparator's one-hot result (`a_gt_b`, `a_lt_b`, `a_eq_b`). It commits a new relation state only after `DEBOUNCE` consecutive identical valid samples. It counts committed entries into each state and flags malformed result codes.

## Interface
- `DEBOUNCE`, default 3: consecutive identical valid samples required to commit; legal range 1..15.
- `CNT_W`, default 8: width of each saturating event counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample strobe; comparator outputs are sampled only when high.
- `a_gt_b`  in  1  comparator A>B.
- `a_lt_b`  in  1  comparator A<B.
- `a_eq_b`  in  1  comparator A==B.
- `clr`  in  1  synchronous clear of counters and `err`.
- `state`  out  2  committed relation: 2'b00 IDLE, 2'b01 EQ, 2'b10 ABOVE, 2'b11 BELOW.
- `state_chg`  out  1  one-cycle pulse on the cycle after a commit edge.
- `gt_cnt`  out  CNT_W  number of entries into ABOVE.
- `lt_cnt`  out  CNT_W  number of entries into BELOW.
- `eq_cnt`  out  CNT_W  number of entries into EQ.
- `err`  out  1  sticky malformed-sample flag.

## Operation
- **Sample classification**, on a valid sample only:
  - 3'b100 (gt,lt,eq) → ABOVE.
  - 3'b010 → BELOW.
  - 3'b001 → EQ.
  - Any other code → illegal.
- **Internal state:**
  - `cand`: candidate class, or NONE.
  - `streak`: 4-bit count, saturating at `DEBOUNCE`.
- **Legal sample:**
  - If class == `cand`: `streak` increments, saturating.
  - Otherwise: `cand` ← class and `streak` ← 1.
- **Commit:** occurs when the updated `streak` equals `DEBOUNCE` and `cand` != `state`. On commit:
  - `state` ← `cand`.
  - `state_chg` pulses.
  - The matching counter increments.
- **No re-commit:** a class equal to the current `state` never re-commits and never re-counts.
- **`in_valid` low:** a cycle with `in_valid` low is a hold. `cand` and `streak` are unchanged, so gaps do not break a streak.
- **FSM:**
  - IDLE → EQ/ABOVE/BELOW, on commit only.
  - Any non-IDLE state → any other non-IDLE state, on commit.
  - No path returns to IDLE except `rst`.
- **Counters:** `CNT_W` bits, saturate at all-ones and hold there.
- **`clr`:**
  - Zeroes all three counters and `err`.
  - Leaves `state`, `cand` and `streak` untouched.
  - Has priority over a coincident increment, so the counter reads 0.
  - A coincident commit still updates `state` and still pulses `state_chg`.
- **Reset (`rst`), asynchronous and effective at any point, including mid-streak:**
  - `state`=2'b00, `state_chg`=0.
  - `gt_cnt`=`lt_cnt`=`eq_cnt`=0, `err`=0.
  - `cand`=NONE, `streak`=0.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Commit occurs on the rising edge that accepts the `DEBOUNCE`-th consecutive identical valid sample.
  - `state`, the counter, and `state_chg`=1 are visible after that edge.
  - `state_chg` returns to 0 after the next edge unless another commit occurs.
- With `DEBOUNCE`=1, every legal valid sample differing from `state` commits on its own edge.
- Minimum spacing between commits is `DEBOUNCE` valid samples.

## Configuration
- Macro: `CMP_RESULT_CHECK_EN`.
- **Defined:**
  - An illegal valid sample sets `err` (sticky until `clr` or `rst`).
  - It also forces `cand` ← NONE and `streak` ← 0, so the next legal sample starts a new streak at 1.
- **Undefined:**
  - Illegal valid samples are treated exactly like `in_valid` low, with no effect on `cand` or `streak`.
  - `err` is tied to 0.
  - The port list is identical in both builds.

## Test plan
All scenarios use `DEBOUNCE`=3 and `CNT_W`=8.
- **Reset values:** assert `rst` → `state`=00, all counters 0, `err`=0, `state_chg`=0.
- **Basic commit:** three valid 3'b100 samples → after the 3rd edge, `state`=10, `gt_cnt`=1, `state_chg` high for exactly one cycle. A 4th 3'b100 sample → no change, no pulse.
- **Streak restart and gaps:**
  - Sequence gt, gt, eq, eq, eq → `state` never reaches 10; `state`=01 after the 5th sample; `eq_cnt`=1, `gt_cnt`=0.
  - Repeat the sequence with `in_valid` low for 2 cycles between samples → same result.
- **Malformed sample:** gt, gt, 3'b110, gt.
  - With `CMP_RESULT_CHECK_EN`: `err`=1 and `state` stays 00; two further gt samples are then needed to reach 10.
  - Without it: `state`=10 after the final gt and `err`=0.
- **Saturation and clear:**
  - Alternate 3×gt / 3×lt blocks 260 times → `gt_cnt`=`lt_cnt`=255, holding.
  - Then assert `clr` on a commit edge → `state` updates, `state_chg`=1, and all counters read 0.
- **Reset mid-operation:** assert `rst` asynchronously after two gt samples → all outputs return to reset values immediately; three new gt samples are required to commit.
